// File: rtl/lb4_cascade_ctrl.sv
// lb4_cascade_ctrl
//
// Command-driven sequencer for a cascade of 4-bit loadable up/down counter slices.
// A host issues LOAD / UP N / DOWN N / HALT commands. The block drives the shared
// slice controls and keeps a shadow copy of the count. When the shadow is known to
// match the cascade (after a LOAD), it checks Q and CO on every step and raises a
// sticky ERR flag if the cascade diverges.
//
// Ports
//   CK, RN          clock (rising edge), asynchronous active-low reset
//   CMD_VALID/READY command handshake; a command is taken on a CK edge with both high
//   CMD_OP          00 LOAD, 01 UP, 10 DOWN, 11 HALT
//   CMD_ARG         LOAD value, or step count N for UP/DOWN
//   CTR_SP          slice clock enable
//   CTR_SD          slice load select (1 = load CTR_D)
//   CTR_CON         direction (1 = up)
//   CTR_CI          carry-in to slice 0 (up: 1 steps, down: 0 steps)
//   CTR_D           parallel load data
//   CTR_Q, CTR_CO   cascade outputs and final carry-out
//   BUSY            high whenever the sequencer is not idle
//   DONE            one-cycle pulse when a command completes
//   TC              one-cycle pulse after a step taken from the terminal count
//   ERR, ERR_CLR    sticky mismatch flag and its synchronous clear
module lb4_cascade_ctrl #(
    parameter int unsigned SLICES = 4,
    localparam int unsigned W = 4 * SLICES
) (
    input  logic         CK,
    input  logic         RN,
    input  logic         CMD_VALID,
    output logic         CMD_READY,
    input  logic [1:0]   CMD_OP,
    input  logic [W-1:0] CMD_ARG,
    output logic         CTR_SP,
    output logic         CTR_SD,
    output logic         CTR_CON,
    output logic         CTR_CI,
    output logic [W-1:0] CTR_D,
    input  logic [W-1:0] CTR_Q,
    input  logic         CTR_CO,
    output logic         BUSY,
    output logic         DONE,
    output logic         TC,
    output logic         ERR,
    input  logic         ERR_CLR
);

    localparam logic [1:0] OpLoad = 2'b00;
    localparam logic [1:0] OpUp   = 2'b01;
    localparam logic [1:0] OpDown = 2'b10;
    localparam logic [1:0] OpHalt = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StFin
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   shadow_q, shadow_d;
    logic [W-1:0]   remaining_q, remaining_d;
    logic           synced_q, synced_d;
    logic           sp_q, sp_d;
    logic           sd_q, sd_d;
    logic           con_q, con_d;
    logic           ci_q, ci_d;
    logic [W-1:0]   d_q, d_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           tc_q, tc_d;
    logic           err_q, err_d;

    logic           cmd_ready;
    logic           accept;
    logic           shadow_ones;
    logic           shadow_zero;
    logic           co_exp;
    logic           term;
    logic           mismatch;

    // Only HALT may interrupt a run; everything else waits for IDLE.
    always_comb begin
        cmd_ready = 1'b0;
        if (RN) begin
            unique case (state_q)
                StIdle:  cmd_ready = 1'b1;
                StRun:   cmd_ready = (CMD_OP == OpHalt);
                default: cmd_ready = 1'b0;
            endcase
        end
    end

    assign CMD_READY = cmd_ready;
    assign accept    = CMD_VALID & cmd_ready;

    // During a RUN cycle the cascade still shows the pre-step value, which the
    // shadow tracks, so CO expectations derive from the shadow directly.
    assign shadow_ones = &shadow_q;
    assign shadow_zero = ~|shadow_q;
    assign co_exp      = con_q ? shadow_ones : ~shadow_zero;
    assign term        = con_q ? shadow_ones : shadow_zero;

    always_comb begin
        mismatch = 1'b0;
        if (synced_q) begin
            if (state_q == StRun) begin
                mismatch = (CTR_Q != shadow_q) || (CTR_CO != co_exp);
            end else if (state_q == StFin) begin
                mismatch = (CTR_Q != shadow_q);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        remaining_d = remaining_q;
        synced_d    = synced_q;
        con_d       = con_q;
        ci_d        = ci_q;
        d_d         = d_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (CMD_OP)
                        OpLoad: begin
                            d_d     = CMD_ARG;
                            state_d = StLoad;
                        end
                        OpUp, OpDown: begin
                            con_d       = (CMD_OP == OpUp);
                            ci_d        = (CMD_OP == OpUp);
                            remaining_d = CMD_ARG;
                            state_d     = (CMD_ARG == '0) ? StFin : StRun;
                        end
                        default: begin
                            state_d = StFin;
                        end
                    endcase
                end
            end
            StLoad: begin
                // The cascade captures d_q on this edge.
                shadow_d = d_q;
                synced_d = 1'b1;
                state_d  = StFin;
            end
            StRun: begin
                // SP is high this cycle, so the cascade steps on this edge even
                // when a HALT is accepted on it.
                shadow_d    = con_q ? (shadow_q + 1'b1) : (shadow_q - 1'b1);
                remaining_d = remaining_q - 1'b1;
                if (accept) begin
                    remaining_d = '0;
                    state_d     = StFin;
                end else if (remaining_q == W'(1)) begin
                    state_d = StFin;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        sp_d   = (state_d == StLoad) || (state_d == StRun);
        sd_d   = (state_d == StLoad);
        busy_d = (state_d != StIdle);
        done_d = (state_d == StFin);
        tc_d   = (state_q == StRun) && term;
        // A fresh mismatch wins over a simultaneous clear.
        err_d  = mismatch | (err_q & ~ERR_CLR);
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q     <= StIdle;
            shadow_q    <= '0;
            remaining_q <= '0;
            synced_q    <= 1'b0;
            sp_q        <= 1'b0;
            sd_q        <= 1'b0;
            con_q       <= 1'b1;
            ci_q        <= 1'b0;
            d_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tc_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            remaining_q <= remaining_d;
            synced_q    <= synced_d;
            sp_q        <= sp_d;
            sd_q        <= sd_d;
            con_q       <= con_d;
            ci_q        <= ci_d;
            d_q         <= d_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tc_q        <= tc_d;
            err_q       <= err_d;
        end
    end

    assign CTR_SP  = sp_q;
    assign CTR_SD  = sd_q;
    assign CTR_CON = con_q;
    assign CTR_CI  = ci_q;
    assign CTR_D   = d_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign TC      = tc_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_lb4_cascade_ctrl.sv
// Directed bench for lb4_cascade_ctrl with a behavioural model of the counter cascade.
module tb_lb4_cascade_ctrl;

    localparam int unsigned SLICES = 4;
    localparam int unsigned W = 4 * SLICES;

    localparam logic [1:0] OpLoad = 2'b00;
    localparam logic [1:0] OpUp   = 2'b01;
    localparam logic [1:0] OpDown = 2'b10;
    localparam logic [1:0] OpHalt = 2'b11;

    logic         ck = 1'b0;
    logic         rn = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = OpLoad;
    logic [W-1:0] cmd_arg = '0;
    logic         ctr_sp, ctr_sd, ctr_con, ctr_ci;
    logic [W-1:0] ctr_d;
    logic [W-1:0] ctr_q;
    logic         ctr_co;
    logic         busy, done, tc, err;
    logic         err_clr = 1'b0;

    logic         fault = 1'b0;
    logic [W-1:0] cnt = '0;

    int n_tests = 0;
    int n_fail  = 0;

    lb4_cascade_ctrl #(.SLICES(SLICES)) dut (
        .CK        (ck),
        .RN        (rn),
        .CMD_VALID (cmd_valid),
        .CMD_READY (cmd_ready),
        .CMD_OP    (cmd_op),
        .CMD_ARG   (cmd_arg),
        .CTR_SP    (ctr_sp),
        .CTR_SD    (ctr_sd),
        .CTR_CON   (ctr_con),
        .CTR_CI    (ctr_ci),
        .CTR_D     (ctr_d),
        .CTR_Q     (ctr_q),
        .CTR_CO    (ctr_co),
        .BUSY      (busy),
        .DONE      (done),
        .TC        (tc),
        .ERR       (err),
        .ERR_CLR   (err_clr)
    );

    initial forever #5 ck = ~ck;

    // Counter cascade model; it has no reset, like the real slices.
    always @(posedge ck) begin
        if (ctr_sp) begin
            if (ctr_sd)                 cnt <= ctr_d;
            else if (ctr_con && ctr_ci) cnt <= cnt + 1'b1;
            else if (!ctr_con && !ctr_ci) cnt <= cnt - 1'b1;
        end
    end

    // The fault pins the observed Q bit0 low without touching the real count.
    assign ctr_q  = fault ? {cnt[W-1:1], 1'b0} : cnt;
    assign ctr_co = ctr_con ? (ctr_ci && (&cnt)) : !(!ctr_ci && (cnt == '0));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents a command right after a clock edge and holds it until it is taken.
    // Returns 1 time unit after the accepting edge (inside cycle k+1).
    task automatic send_cmd(input logic [1:0] op, input logic [W-1:0] arg);
        int waited;
        @(posedge ck); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        waited    = 0;
        while (!cmd_ready && waited < 50) begin
            @(posedge ck); #1;
            waited++;
        end
        @(posedge ck); #1;
        cmd_valid = 1'b0;
        cmd_op    = OpLoad;
    endtask

    // Watches cycles k+1, k+2, ... until DONE; done_at is the index of the DONE
    // cycle relative to the accepting edge, 0 if it never came.
    task automatic run_and_count(input int max_cyc, input logic exp_dir,
                                 output int sp_n, output int tc_n, output int dir_n,
                                 output int done_at);
        sp_n = 0; tc_n = 0; dir_n = 0; done_at = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge ck);
            if (ctr_sp) sp_n++;
            if (ctr_sp && !ctr_sd && ctr_con == exp_dir && ctr_ci == exp_dir) dir_n++;
            if (tc) tc_n++;
            if (done) begin
                done_at = i;
                break;
            end
        end
    endtask

    initial begin
        int sp_n, tc_n, dir_n, done_at;

        // Reset values while RN is held low
        #12;
        check_eq("rst_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_sp",    32'(ctr_sp),    32'd0);
        check_eq("rst_sd",    32'(ctr_sd),    32'd0);
        check_eq("rst_con",   32'(ctr_con),   32'd1);
        check_eq("rst_ci",    32'(ctr_ci),    32'd0);
        check_eq("rst_d",     32'(ctr_d),     32'd0);
        check_eq("rst_flags", {28'd0, busy, done, tc, err}, 32'd0);
        @(posedge ck); #1;
        rn = 1'b1;
        @(negedge ck);
        check_eq("idle_ready", 32'(cmd_ready), 32'd1);

        // LOAD 0x1234: one load cycle, DONE at k+2, READY back at k+3
        send_cmd(OpLoad, 16'h1234);
        @(negedge ck);
        check_eq("ld_sp_sd", {30'd0, ctr_sp, ctr_sd}, 32'd3);
        check_eq("ld_d",     32'(ctr_d), 32'h1234);
        check_eq("ld_done0", 32'(done), 32'd0);
        @(negedge ck);
        check_eq("ld_done",  {30'd0, done, ctr_sp}, 32'd2);
        check_eq("ld_q",     32'(ctr_q), 32'h1234);
        check_eq("ld_ready_fin", 32'(cmd_ready), 32'd0);
        @(negedge ck);
        check_eq("ld_idle",  {29'd0, cmd_ready, busy, done}, 32'd4);
        check_eq("ld_err",   32'(err), 32'd0);

        // LOAD 0xFFFD, UP 5: wraps through 0xFFFF -> one TC
        send_cmd(OpLoad, 16'hFFFD);
        run_and_count(10, 1'b1, sp_n, tc_n, dir_n, done_at);
        check_eq("ld2_done_at", 32'(done_at), 32'd2);
        send_cmd(OpUp, 16'd5);
        run_and_count(20, 1'b1, sp_n, tc_n, dir_n, done_at);
        check_eq("up5_sp",      32'(sp_n),    32'd5);
        check_eq("up5_dir",     32'(dir_n),   32'd5);
        check_eq("up5_tc",      32'(tc_n),    32'd1);
        check_eq("up5_done_at", 32'(done_at), 32'd6);
        check_eq("up5_q",       32'(ctr_q),   32'h0002);
        check_eq("up5_err",     32'(err),     32'd0);

        // LOAD 2, DOWN 4: borrow at zero -> one TC, ends at 0xFFFE
        send_cmd(OpLoad, 16'h0002);
        run_and_count(10, 1'b1, sp_n, tc_n, dir_n, done_at);
        send_cmd(OpDown, 16'd4);
        run_and_count(20, 1'b0, sp_n, tc_n, dir_n, done_at);
        check_eq("dn4_sp",      32'(sp_n),    32'd4);
        check_eq("dn4_dir",     32'(dir_n),   32'd4);
        check_eq("dn4_tc",      32'(tc_n),    32'd1);
        check_eq("dn4_done_at", 32'(done_at), 32'd5);
        check_eq("dn4_q",       32'(ctr_q),   32'hFFFE);
        check_eq("dn4_err",     32'(err),     32'd0);

        // LOAD 0, UP 100, HALT accepted at the end of the 10th SP cycle
        send_cmd(OpLoad, 16'h0000);
        run_and_count(10, 1'b1, sp_n, tc_n, dir_n, done_at);
        send_cmd(OpUp, 16'd100);
        sp_n = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge ck);
            if (ctr_sp) sp_n++;
            if (i == 5) check_eq("run_ready_nonhalt", 32'(cmd_ready), 32'd0);
        end
        @(posedge ck); #1;
        cmd_valid = 1'b1;
        cmd_op    = OpHalt;
        @(negedge ck);
        if (ctr_sp) sp_n++;
        check_eq("halt_ready", 32'(cmd_ready), 32'd1);
        @(posedge ck); #1;
        cmd_valid = 1'b0;
        cmd_op    = OpLoad;
        @(negedge ck);
        check_eq("halt_sp_cnt", 32'(sp_n), 32'd10);
        check_eq("halt_sp_off", 32'(ctr_sp), 32'd0);
        check_eq("halt_done",   32'(done), 32'd1);
        check_eq("halt_q",      32'(ctr_q), 32'h000A);
        @(negedge ck);
        check_eq("halt_busy",   {30'd0, busy, done}, 32'd0);

        // HALT from IDLE: no counter activity, DONE next cycle
        send_cmd(OpHalt, 16'd0);
        run_and_count(10, 1'b1, sp_n, tc_n, dir_n, done_at);
        check_eq("ihalt_done_at", 32'(done_at), 32'd1);
        check_eq("ihalt_sp",      32'(sp_n),    32'd0);

        // Q bit0 stuck at 0 during UP 3 from 0x000A
        fault = 1'b1;
        send_cmd(OpUp, 16'd3);
        run_and_count(10, 1'b1, sp_n, tc_n, dir_n, done_at);
        check_eq("flt_done_at", 32'(done_at), 32'd4);
        check_eq("flt_err",     32'(err), 32'd1);
        fault = 1'b0;
        @(posedge ck); #1;
        err_clr = 1'b1;
        @(posedge ck); #1;
        err_clr = 1'b0;
        @(negedge ck);
        check_eq("errclr_clean", 32'(err), 32'd0);

        // Clear held while a new fault is seen: ERR must still rise
        fault   = 1'b1;
        err_clr = 1'b1;
        send_cmd(OpUp, 16'd3);
        @(negedge ck);
        @(negedge ck);
        check_eq("errclr_vs_fault", 32'(err), 32'd1);
        run_and_count(10, 1'b1, sp_n, tc_n, dir_n, done_at);
        fault   = 1'b0;
        err_clr = 1'b0;
        check_eq("flt2_done_after", 32'(done_at), 32'd2);
        @(posedge ck); #1;
        err_clr = 1'b1;
        @(posedge ck); #1;
        err_clr = 1'b0;

        // UP 0: straight to FIN, no SP
        send_cmd(OpUp, 16'd0);
        check_eq("up0_sp_k1", 32'(ctr_sp), 32'd0);
        run_and_count(10, 1'b1, sp_n, tc_n, dir_n, done_at);
        check_eq("up0_done_at", 32'(done_at), 32'd1);
        check_eq("up0_sp",      32'(sp_n),    32'd0);
        check_eq("up0_err",     32'(err),     32'd0);

        // Reset in the middle of a run
        send_cmd(OpUp, 16'd20);
        @(negedge ck);
        @(negedge ck);
        @(negedge ck);
        check_eq("mid_busy", 32'(busy), 32'd1);
        rn = 1'b0;
        #1;
        check_eq("mid_rst_ctl", {27'd0, cmd_ready, ctr_sp, ctr_sd, ctr_con, ctr_ci}, 32'd2);
        check_eq("mid_rst_d",   32'(ctr_d), 32'd0);
        check_eq("mid_rst_flags", {28'd0, busy, done, tc, err}, 32'd0);
        @(posedge ck); #1;
        rn = 1'b1;

        // UP before any LOAD: cascade differs from the reset shadow, no ERR
        send_cmd(OpUp, 16'd5);
        run_and_count(20, 1'b1, sp_n, tc_n, dir_n, done_at);
        check_eq("nosync_done_at", 32'(done_at), 32'd6);
        check_eq("nosync_sp",      32'(sp_n),    32'd5);
        @(negedge ck);
        check_eq("nosync_err",     32'(err),     32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lb4_cascade_ctrl.md
Name: lb4_cascade_ctrl

Overview:
- Command-driven sequencer for a cascade of 4-bit loadable up/down counter slices, SLICES long, with total width W = 4*SLICES.
- Drives the shared slice controls: SP (clock enable), SD (load select), CON (direction), CI (carry-in to slice 0) and the parallel load bus D.
- Monitors the cascade Q and final CO. Keeps an internal shadow count and flags any divergence between shadow and cascade.
- Sits between a host command port and the counter slices on the same CK.

Parameters:
SLICES, 4, number of cascaded 4-bit slices; W = 4*SLICES

Ports:
CK  in  1  clock, rising edge
RN  in  1  asynchronous reset, active low
CMD_VALID  in  1  command offered
CMD_READY  out  1  command accepted on a CK edge when VALID&READY
CMD_OP  in  2  00 LOAD, 01 UP, 10 DOWN, 11 HALT
CMD_ARG  in  W  LOAD: value; UP/DOWN: step count N
CTR_SP  out  1  slice clock enable
CTR_SD  out  1  slice load select (1 = load D)
CTR_CON  out  1  direction (1 = up, 0 = down)
CTR_CI  out  1  carry-in (up: 1 = step; down: 0 = step)
CTR_D  out  W  load data
CTR_Q  in  W  cascade outputs
CTR_CO  in  1  cascade carry-out (up: 1 at all-ones with CI=1; down: 0 at zero with CI=0)
BUSY  out  1  state != IDLE
DONE  out  1  one-cycle pulse when a command completes
TC  out  1  one-cycle pulse, the cycle after a terminal carry/borrow step
ERR  out  1  sticky mismatch flag
ERR_CLR  in  1  synchronous clear of ERR

Behaviour:
- Reset (RN=0, async):
  - State IDLE; CTR_SP=0, CTR_SD=0, CTR_CON=1, CTR_CI=0, CTR_D=0.
  - BUSY=0, DONE=0, TC=0, ERR=0.
  - shadow=0, remaining=0, synced=0.
  - CMD_READY=0 while RN=0.
- All outputs except CMD_READY are registered.
- CMD_READY is combinational: 1 in IDLE; 1 in RUN only when CMD_OP=HALT; 0 otherwise.
- States:
  - IDLE: SP=0, so the counter holds.
  - LOAD:
    - Exactly one cycle with SP=1, SD=1, D=arg.
    - shadow<=arg, synced<=1.
    - Next state FIN.
  - RUN:
    - SP=1, SD=0. CON/CI fixed at accept: UP gives CON=1, CI=1; DOWN gives CON=0, CI=0.
    - Lasts exactly N cycles. Each cycle: shadow<=shadow±1 mod 2^W, remaining<=remaining-1.
    - When remaining=1, next state FIN.
  - FIN:
    - SP=0; compare CTR_Q against shadow.
    - DONE=1 for this cycle; next state IDLE.
- Latency:
  - LOAD: accept at edge k; load captured at edge k+1; DONE high in cycle k+2; READY again in cycle k+3.
  - UP/DOWN N>=1: SP high in cycles k+1..k+N; DONE in cycle k+N+1.
- N=0: go directly to FIN. No SP pulse, DONE in cycle k+1.
- Checks, only when synced=1:
  - Every RUN cycle and in FIN: CTR_Q must equal shadow.
  - Every RUN cycle: CTR_CO must equal the expected value. Up: (shadow==all-ones). Down: inverse of (shadow==0).
  - Any mismatch sets ERR on the next edge.
- ERR clearing:
  - ERR_CLR clears ERR.
  - If ERR_CLR and a new mismatch occur in the same cycle, ERR stays 1.
- TC: registered pulse the cycle after a RUN step where the shadow terminal condition held.
- Wrap-around is legal; TC pulses once per wrap.
- HALT:
  - In RUN: accepted immediately; SP=0 from the next cycle; remaining discarded; go to FIN.
  - In IDLE: accepted, no counter activity, DONE pulses next cycle.
- Non-HALT commands in RUN/LOAD/FIN are stalled (READY=0).
- Reset mid-operation: the block returns to reset values; the counter slices keep their contents. synced=0 suppresses checks until the next LOAD.

Test Plan:
- Reset, then LOAD 0x1234 → exactly one cycle of SP=1, SD=1, D=0x1234; DONE two cycles after accept; CTR_Q=0x1234; ERR=0.
- LOAD 0xFFFD, then UP N=5 → 5 SP cycles; CTR_Q=0x0002; one TC pulse, after the step from 0xFFFF; DONE at accept+6.
- LOAD 0x0002, then DOWN N=4 → CON=0, CI=0 for 4 cycles; CTR_Q=0xFFFE; one TC pulse (borrow at 0x0000); ERR=0.
- LOAD 0x0000, UP N=100, HALT issued after 10 SP cycles → SP drops the next cycle; CTR_Q=0x000A; DONE in the following cycle; BUSY=0 afterwards.
- UP N=3 with the bench model forcing CTR_Q bit0 stuck at 0 → ERR=1 by FIN; ERR_CLR with no fault → ERR=0; ERR_CLR during an active fault → ERR remains 1.
- UP N=0 → DONE next cycle with no SP. Assert RN mid-RUN → outputs at reset values; UP issued before any LOAD → no ERR regardless of CTR_Q.
